// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, the round-constant table and mode decode helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'd0,
        AES192 = 2'd1,
        AES256 = 2'd2
    } aes_mode_e;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Mode 3 is not a legal AES variant and falls back to AES-128.
    function automatic logic [3:0] nk_of(input logic [1:0] m);
        case (aes_mode_e'(m))
            AES192:  return 4'd6;
            AES256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] m);
        case (aes_mode_e'(m))
            AES192:  return 4'd12;
            AES256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse by x^254, then the FIPS-197 affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] pw;

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
    always_comb begin
        inv = 8'h01;
        pw  = a;
        for (int k = 1; k < 8; k++) begin
            pw  = gmul(pw, pw);
            inv = gmul(inv, pw);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key expansion, one word per cycle, round keys out on a valid/ready stream.
// Define AES_KS_REVERSE_EN to add a round-key buffer and reverse-order (decrypt) replay.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_MAX_BITS = 256,
    parameter int RK_IDX_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [1:0]              mode,
    input  logic                    dir,
    input  logic [KEY_MAX_BITS-1:0] key,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic [127:0]            round_key,
    output logic [RK_IDX_W-1:0]     rk_idx,
    output logic                    rk_last
);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_REPLAY} state_e;

    state_e                  state_q, state_d;
    logic [KEY_MAX_BITS-1:0] key_q;
    logic [3:0]              nk_q, nr_q;
    logic [5:0]              i_q;
    logic [2:0]              j_q;
    logic [3:0]              rc_q;
    logic [7:0][31:0]        win_q;
    logic [2:0][31:0]        asm_q;
    logic                    rk_valid_q, rk_last_q;
    rkey_t                   round_key_q;
    logic [RK_IDX_W-1:0]     rk_idx_q;

    word_t     prev_w, old_w, sub_in, sub_out, w_new;
    rkey_t     rk_new;
    logic [5:0] last_word;
    logic      key_phase, gen, rk_fire, start_fire, rev;

`ifdef AES_KS_REVERSE_EN
    logic  rev_q;
    rkey_t rkbuf [15];
    assign rev = rev_q;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign rev        = 1'b0;
`endif

    assign start_ready = (state_q == S_IDLE);
    assign start_fire  = start_valid && start_ready;
    assign rk_fire     = rk_valid_q && rk_ready;
    assign last_word   = {nr_q, 2'b11};
    assign key_phase   = i_q < {2'b00, nk_q};

    // win_q[k] holds w[i-1-k]
    assign prev_w = win_q[0];
    assign old_w  = win_q[3'(nk_q - 4'd1)];
    assign sub_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
    end

    always_comb begin
        w_new = old_w ^ prev_w;
        if (key_phase)
            w_new = key_q[KEY_MAX_BITS-1 -: 32];
        else if (j_q == 3'd0)
            w_new = old_w ^ sub_out ^ {RCON[rc_q], 24'h0};
        else if (nk_q == 4'd8 && j_q == 3'd4)
            w_new = old_w ^ sub_out;
    end

    assign rk_new = {asm_q[0], asm_q[1], asm_q[2], w_new};

    // Only the word that completes a round key can stall; replay fills never stall.
    assign gen = (state_q == S_EXPAND) && (i_q <= last_word)
               && (i_q[1:0] != 2'd3 || !rk_valid_q || rk_ready || rev);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_valid) state_d = S_EXPAND;
            S_EXPAND: begin
                if (rk_fire && rk_last_q) state_d = S_IDLE;
`ifdef AES_KS_REVERSE_EN
                if (gen && rev && i_q == last_word) state_d = S_REPLAY;
`endif
            end
`ifdef AES_KS_REVERSE_EN
            S_REPLAY: if (rk_fire && rk_last_q) state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q       <= '0;
            nk_q        <= 4'd4;
            nr_q        <= 4'd10;
            i_q         <= '0;
            j_q         <= '0;
            rc_q        <= '0;
            win_q       <= '0;
            asm_q       <= '0;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
            round_key_q <= '0;
            rk_idx_q    <= '0;
`ifdef AES_KS_REVERSE_EN
            rev_q       <= 1'b0;
`endif
        end else begin
            if (start_fire) begin
                key_q <= key;
                nk_q  <= nk_of(mode);
                nr_q  <= nr_of(mode);
                i_q   <= '0;
                j_q   <= '0;
                rc_q  <= '0;
`ifdef AES_KS_REVERSE_EN
                rev_q <= dir;
`endif
            end
            if (rk_fire) begin
                rk_valid_q <= 1'b0;
                rk_last_q  <= 1'b0;
            end
            if (gen) begin
                win_q <= {win_q[6:0], w_new};
                key_q <= key_q << 32;
                i_q   <= i_q + 6'd1;
                j_q   <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                if (!key_phase && j_q == 3'd0) rc_q <= rc_q + 4'd1;
                if (i_q[1:0] != 2'd3)
                    asm_q[i_q[1:0]] <= w_new;
                else if (!rev || i_q == last_word) begin
                    // In reverse mode the final round key goes straight out as the first replay entry.
                    round_key_q <= rk_new;
                    rk_idx_q    <= RK_IDX_W'(i_q[5:2]);
                    rk_last_q   <= !rev && (i_q[5:2] == nr_q);
                    rk_valid_q  <= 1'b1;
                end
            end
`ifdef AES_KS_REVERSE_EN
            if (state_q == S_REPLAY && rk_fire && !rk_last_q) begin
                round_key_q <= rkbuf[rk_idx_q - 1'b1];
                rk_idx_q    <= rk_idx_q - 1'b1;
                rk_last_q   <= (rk_idx_q == RK_IDX_W'(1));
                rk_valid_q  <= 1'b1;
            end
`endif
        end
    end

`ifdef AES_KS_REVERSE_EN
    always_ff @(posedge clk) begin
        if (gen && i_q[1:0] == 2'd3) rkbuf[i_q[5:2]] <= rk_new;
    end
`endif

    assign rk_valid  = rk_valid_q;
    assign rk_last   = rk_last_q;
    assign round_key = round_key_q;
    assign rk_idx    = rk_idx_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Randomized bench for aes_key_expander against a table-driven FIPS-197 key schedule model.
module tb_aes_key_expander;

    logic         clk = 1'b0, rst = 1'b1;
    logic         start_valid = 1'b0, start_ready;
    logic [1:0]   mode = 2'd0;
    logic         dir = 1'b0;
    logic [255:0] key = '0;
    logic         rk_valid, rk_ready = 1'b1, rk_last;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;

    always #5 clk = ~clk;

    aes_key_expander #(.KEY_MAX_BITS(256), .RK_IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .mode(mode), .dir(dir), .key(key), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .round_key(round_key), .rk_idx(rk_idx), .rk_last(rk_last)
    );

`ifdef AES_KS_REVERSE_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    typedef struct {
        logic [127:0] k;
        int           idx;
        bit           last;
    } exp_t;

    int           errors = 0, checks = 0;
    exp_t         exp_q[$];
    logic [127:0] obs [15];
    logic [127:0] model_rk [15];
    logic [127:0] first_key;
    int           first_idx, n_out;
    bit           rand_ready = 1'b0;
    logic [7:0]   expt [256];
    logic [7:0]   logt [256];

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse via log/antilog tables (generator 3), then the bitwise affine formula.
    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] b, s;
        b = (a == 8'h00) ? 8'h00 : expt[(255 - int'(logt[a])) % 255];
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic expand(input logic [255:0] k, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) w[i] = k[255-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    rc = 8'h01;
                    for (int j = 1; j < i/nk; j++) rc = xt(rc);
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                end else if (nk == 8 && i % nk == 4) t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Output checker: every presented round key against the expected queue, and stability under stall.
    logic         hold_pend = 1'b0;
    logic [127:0] hold_key;
    logic [3:0]   hold_idx;
    always @(negedge clk) begin
        if (rst) hold_pend = 1'b0;
        else begin
            if (hold_pend)
                chk("hold_stable", {rk_valid, rk_idx, round_key}, {1'b1, hold_idx, hold_key});
            if (rk_valid) begin
                if (exp_q.size() == 0) chk("extra_output", rk_valid, 1'b0);
                else begin
                    chk("round_key", {rk_last, rk_idx, round_key},
                        {exp_q[0].last, 4'(exp_q[0].idx), exp_q[0].k});
                    if (rk_ready) begin
                        if (n_out == 0) begin first_key = round_key; first_idx = int'(rk_idx); end
                        obs[rk_idx] = round_key;
                        n_out++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            hold_pend = rk_valid && !rk_ready;
            hold_key  = round_key;
            hold_idx  = rk_idx;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic queue_run(input logic [255:0] k, input logic [1:0] m, input bit d, output int nr);
        int nk, rr;
        bit rev;
        nk = (m == 2'd1) ? 6 : (m == 2'd2) ? 8 : 4;
        nr = nk + 6;
        expand(k, nk, nr);
        rev = d && REV_EN;
        for (int r = 0; r <= nr; r++) begin
            rr = rev ? nr - r : r;
            exp_q.push_back('{model_rk[rr], rr, r == nr});
        end
        n_out = 0;
        key = k; mode = m; dir = d; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0; key = rand256(); mode = 2'($urandom); dir = ~d;
    endtask

    task automatic run(input logic [255:0] k, input logic [1:0] m, input bit d,
                       input bit poke, input bit lat);
        int nr, c;
        queue_run(k, m, d, nr);
        if (lat) begin
            c = 0;
            do begin @(posedge clk); #1; c++; end while (!rk_valid && c < 20);
            chk("first_valid_latency", c, 4);
        end
        for (c = 0; c < 3000 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
            start_valid = poke && (c % 7 == 3);
            if (start_valid) begin key = rand256(); mode = 2'($urandom); end
        end
        start_valid = 1'b0;
        chk("run_timeout", exp_q.size(), 0);
        exp_q.delete();
        chk("key_count", n_out, nr + 1);
        @(posedge clk); #1;
        chk("idle_after_run", {start_ready, rk_valid}, 2'b10);
    endtask

    localparam logic [127:0] K128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] R128_10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    initial begin : main
        logic [7:0] x;
        int nr;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            expt[i] = x; logt[x] = 8'(i);
            x = x ^ xt(x);
        end
        expt[255] = 8'h01;
        logt[0]   = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rk_valid", rk_valid, 1'b0);
        chk("reset_round_key", round_key, '0);
        chk("reset_rk_idx", rk_idx, 4'd0);
        chk("reset_rk_last", rk_last, 1'b0);
        chk("reset_start_ready", start_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // AES-128 reference vector
        run({K128, 128'h0}, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("model_128_r1", model_rk[1], 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
        chk("dut_128_r0", obs[0], K128);
        chk("dut_128_r1", obs[1], 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
        chk("dut_128_r10", obs[10], R128_10);

        // AES-192 reference vector
        run({192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0}, 2'd1, 1'b0, 1'b0, 1'b1);
        chk("model_192_r12", model_rk[12], 128'he98ba06f_448c773c_8ecc7204_01002202);
        chk("dut_192_r1", obs[1], 128'h62f8ead2_522c6b7b_fe0c91f7_2402f5a5);
        chk("dut_192_r12", obs[12], 128'he98ba06f_448c773c_8ecc7204_01002202);

        // AES-256 reference vector
        run(256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4,
            2'd2, 1'b0, 1'b0, 1'b1);
        chk("model_256_r2", model_rk[2], 128'h9ba35411_8e6925af_a51a8b5f_2067fcde);
        chk("dut_256_r2", obs[2], 128'h9ba35411_8e6925af_a51a8b5f_2067fcde);
        chk("dut_256_r14", obs[14], 128'hfe4890d1_e6188d0b_046df344_706c631e);

        // Stalls and ignored mid-run starts
        rand_ready = 1'b1;
        run({K128, 128'h0}, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("stall_128_r10", obs[10], R128_10);
        run(rand256(), 2'd3, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of an AES-256 expansion
        rand_ready = 1'b0;
        queue_run(rand256(), 2'd2, 1'b0, nr);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("abort_rk_valid", rk_valid, 1'b0);
        chk("abort_start_ready", start_ready, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_quiet", rk_valid, 1'b0);
        run({K128, 128'h0}, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("post_abort_r10", obs[10], R128_10);

        // Direction request: reverse replay when compiled in, forward otherwise
        run({K128, 128'h0}, 2'd0, 1'b1, 1'b0, 1'b0);
        chk("dir1_first_idx", first_idx, REV_EN ? 10 : 0);
        chk("dir1_first_key", first_key, REV_EN ? R128_10 : K128);
        chk("dir1_r0", obs[0], K128);

        rand_ready = 1'b1;
        for (int n = 0; n < 6; n++)
            run(rand256(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Parametrised successor to the AES-128 key schedule.
- Expands an AES-128, AES-192 or AES-256 cipher key one 32-bit word per cycle (FIPS-197 KeyExpansion).
- Emits round keys 0..Nr as 128-bit words over a valid/ready stream.
- Feeds the multi-mode cipher datapath; accepts a new key only when idle.

Parameters:
KEY_MAX_BITS, 256, width of key port; key is left-aligned; must be 256 for full mode support
RK_IDX_W, 4, width of round index output (covers 0..14)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start_valid  in  1  request expansion of key/mode
start_ready  out  1  high only in IDLE
mode  in  2  0=AES-128 (Nk=4,Nr=10), 1=AES-192 (Nk=6,Nr=12), 2=AES-256 (Nk=8,Nr=14), 3 treated as AES-128
dir  in  1  0=forward order, 1=reverse order (used only with AES_KS_REVERSE_EN)
key  in  KEY_MAX_BITS  cipher key; word 0 = key[255:224]; AES-128 uses [255:128], AES-192 uses [255:64]
rk_valid  out  1  round_key holds a valid round key
rk_ready  in  1  consumer accepts round key
round_key  out  128  w[4r] at [127:96] .. w[4r+3] at [31:0]
rk_idx  out  RK_IDX_W  round number r of round_key
rk_last  out  1  high with final round key of the sequence

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; rk_valid=0; round_key=0; rk_idx=0; rk_last=0; word counter=0; window cleared. Reset mid-expansion aborts with no further output.
- States: IDLE -> EXPAND -> IDLE; REPLAY additionally when the optional feature is compiled in.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready: latch key, Nk/Nr from mode, dir; i=0; go EXPAND.
- EXPAND, word generation, one word per cycle:
  - i < Nk: w[i] = key word i.
  - Otherwise w[i] = w[i-Nk] ^ t, where:
    - i%Nk==0: t = SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk].
    - Nk==8 && i%Nk==4: t = SubWord(w[i-1]).
    - Otherwise: t = w[i-1].
  - Sliding window keeps the last 8 words.
  - Words i%4 = 0..2 go to a 3-word assembly buffer.
  - Word i%4==3 loads {buf, w[i]} into the output register with rk_idx=i/4, and sets rk_valid.
- Backpressure:
  - A word with i%4==3 is generated only if !rk_valid || rk_ready in that cycle; otherwise i holds and the window is unchanged.
  - Words with i%4 != 3 never stall.
- Latency: start accepted at edge E0; word i produced at edge E(i+1); rk_valid first high after E4. With rk_ready=1 throughout, round r is presented after E(4r+4). Totals: 44/52/60 cycles for 128/192/256.
- rk_last=1 with rk_idx==Nr.
  - When rk_valid && rk_ready && rk_last: rk_valid=0 and return to IDLE at that edge.
  - A start in that same cycle is ignored because start_ready=0.
- start_valid outside IDLE is ignored. Key/mode changes after acceptance have no effect.
- rk_valid, once high, holds with round_key stable until rk_ready.

Optional Feature:
- Macro: AES_KS_REVERSE_EN.
- Defined:
  - 15x128 round-key buffer.
  - If the latched dir=1, EXPAND writes each round key to buffer[r] and keeps rk_valid=0; generation never stalls.
  - After word 4Nr+3, go to REPLAY: emit buffer[Nr] down to buffer[0] with rk_idx descending and rk_last on idx 0, same valid/ready rules.
  - dir=0 behaves as forward.
- Undefined: no buffer; dir ignored; forward only.

Decomposition:
- Shared package aes_pkg:
  - mode enum (AES128/AES192/AES256).
  - Rcon table (01,02,04,08,10,20,40,80,1b,36).
  - Functions nk_of(mode) and nr_of(mode).
  - Word and round-key typedefs.
- Sub-module aes_sbox: combinational byte S-box, 4 instances for SubWord.

Test Plan:
- AES-128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1:
  - round 0 = key;
  - round 1 = a0fafe17_88542cb1_23a33939_2a6c7605;
  - round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6 with rk_last;
  - first rk_valid 4 cycles after accept, 11 keys total.
- AES-192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b:
  - round 1 = 62f8ead2_522c6b7b_fe0c91f7_2402f5a5;
  - round 12 = e98ba06f_448c773c_8ecc7204_01002202, rk_idx=12, rk_last.
- AES-256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4:
  - round 2 = 9ba35411_8e6925af_a51a8b5f_2067fcde;
  - round 14 = fe4890d1_e6188d0b_046df344_706c631e.
- AES-128 with random rk_ready stalls:
  - identical key sequence;
  - round_key and rk_idx stable while rk_valid && !rk_ready;
  - start_valid pulses mid-run ignored.
- Reset asserted at word 20 of AES-256:
  - next cycle rk_valid=0, start_ready=1;
  - a fresh AES-128 run is correct.
- With AES_KS_REVERSE_EN, AES-128, dir=1:
  - first output rk_idx=10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  - last output rk_idx=0 = key with rk_last.
